// File: rtl/csr_rmw_ctrl.sv
// CSR read-modify-write controller: serialises one Zicsr instruction at a time
// through a single-port CSR RAM and serves the mcycle/minstret counters internally.
module csr_rmw_ctrl #(
    parameter int MXLEN = 32
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [11:0]      i_req_addr,
    input  logic [2:0]       i_req_funct3,
    input  logic [MXLEN-1:0] i_req_rs1_data,
    input  logic [4:0]       i_req_uimm,
    input  logic [4:0]       i_req_rd_addr,
    input  logic             i_instret_tick,
    output logic             o_ram_en,
    output logic             o_ram_we,
    output logic [11:0]      o_ram_addr,
    output logic [MXLEN-1:0] o_ram_wdata,
    input  logic [MXLEN-1:0] i_ram_rdata,
    output logic             o_rsp_valid,
    output logic [MXLEN-1:0] o_rd_data,
    output logic [4:0]       o_rd_addr,
    output logic             o_rd_we,
    output logic             o_illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        EXEC = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [11:0]      addr_reg;
    logic [2:0]       funct3_reg;
    logic [MXLEN-1:0] rs1_reg;
    logic [4:0]       uimm_reg;
    logic [4:0]       rd_reg;

    logic [2*MXLEN-1:0] mcycle_reg, mcycle_next;
    logic [2*MXLEN-1:0] minstret_reg, minstret_next;

    logic [MXLEN-1:0] rd_data_reg;
    logic [4:0]       rd_addr_reg;
    logic             rd_we_reg;
    logic             illegal_reg;

    logic             accept;
    logic             sel_cyc_lo, sel_cyc_hi, sel_ins_lo, sel_ins_hi;
    logic             is_counter;
    logic             write_req;
    logic             illegal;
    logic             do_write;
    logic             ram_write;
    logic             cnt_write;
    logic [MXLEN-1:0] counter_val;
    logic [MXLEN-1:0] old_val;
    logic [MXLEN-1:0] operand;
    logic [MXLEN-1:0] new_val;

    // Ready is forced low while reset is held, even though the state is already IDLE.
    assign o_req_ready = (state_reg == IDLE) && i_nrst;
    assign accept      = i_req_valid && o_req_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RD;
            RD:      state_next = EXEC;
            EXEC:    state_next = RSP;
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- request capture ----------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            addr_reg   <= '0;
            funct3_reg <= '0;
            rs1_reg    <= '0;
            uimm_reg   <= '0;
            rd_reg     <= '0;
        end else if (accept) begin
            addr_reg   <= i_req_addr;
            funct3_reg <= i_req_funct3;
            rs1_reg    <= i_req_rs1_data;
            uimm_reg   <= i_req_uimm;
            rd_reg     <= i_req_rd_addr;
        end
    end

    // ---------------- decode of the latched request ----------------
    always_comb begin
        sel_cyc_lo = 1'b0;
        sel_cyc_hi = 1'b0;
        sel_ins_lo = 1'b0;
        sel_ins_hi = 1'b0;
        case (addr_reg)
            12'hB00, 12'hC00: sel_cyc_lo = 1'b1;
            12'hB80, 12'hC80: sel_cyc_hi = 1'b1;
            12'hB02, 12'hC02: sel_ins_lo = 1'b1;
            12'hB82, 12'hC82: sel_ins_hi = 1'b1;
            default: ;
        endcase
    end

    assign is_counter = sel_cyc_lo || sel_cyc_hi || sel_ins_lo || sel_ins_hi;

    // RW/RWI always write; set/clear forms write only with a non-zero rs1 field.
    assign write_req = (funct3_reg[1:0] == 2'b01) || (uimm_reg != 5'd0);
    assign illegal   = (funct3_reg[1:0] == 2'b00) ||
                       (write_req && (addr_reg[11:10] == 2'b11));

    always_comb begin
        counter_val = '0;
        if (sel_cyc_lo) counter_val = mcycle_reg[MXLEN-1:0];
        if (sel_cyc_hi) counter_val = mcycle_reg[2*MXLEN-1:MXLEN];
        if (sel_ins_lo) counter_val = minstret_reg[MXLEN-1:0];
        if (sel_ins_hi) counter_val = minstret_reg[2*MXLEN-1:MXLEN];
    end

    assign old_val = is_counter ? counter_val : i_ram_rdata;
    assign operand = funct3_reg[2] ? {{(MXLEN-5){1'b0}}, uimm_reg} : rs1_reg;

    always_comb begin
        new_val = old_val;
        case (funct3_reg[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = old_val | operand;
            2'b11:   new_val = old_val & ~operand;
            default: new_val = old_val;
        endcase
    end

    assign do_write  = (state_reg == EXEC) && write_req && !illegal;
    assign ram_write = do_write && !is_counter;
    assign cnt_write = do_write && is_counter;

    // ---------------- RAM port ----------------
    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (state_reg == RD && !is_counter) begin
            o_ram_en   = 1'b1;
            o_ram_addr = addr_reg;
        end
        if (ram_write) begin
            o_ram_en    = 1'b1;
            o_ram_we    = 1'b1;
            o_ram_addr  = addr_reg;
            o_ram_wdata = new_val;
        end
    end

    // ---------------- counters ----------------
    // A write to either half suppresses that counter's increment for the whole cycle.
    always_comb begin
        mcycle_next   = mcycle_reg + 1'b1;
        minstret_next = minstret_reg + {{(2*MXLEN-1){1'b0}}, i_instret_tick};
        if (cnt_write && sel_cyc_lo) mcycle_next   = {mcycle_reg[2*MXLEN-1:MXLEN], new_val};
        if (cnt_write && sel_cyc_hi) mcycle_next   = {new_val, mcycle_reg[MXLEN-1:0]};
        if (cnt_write && sel_ins_lo) minstret_next = {minstret_reg[2*MXLEN-1:MXLEN], new_val};
        if (cnt_write && sel_ins_hi) minstret_next = {new_val, minstret_reg[MXLEN-1:0]};
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
        end
    end

    // ---------------- response ----------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_data_reg <= '0;
            rd_addr_reg <= '0;
            rd_we_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (state_reg == EXEC) begin
            rd_data_reg <= old_val;
            rd_addr_reg <= rd_reg;
            rd_we_reg   <= !illegal && (rd_reg != 5'd0);
            illegal_reg <= illegal;
        end
    end

    // Strobes are qualified by RSP so they never linger after the response cycle.
    assign o_rsp_valid = (state_reg == RSP);
    assign o_rd_data   = rd_data_reg;
    assign o_rd_addr   = rd_addr_reg;
    assign o_rd_we     = rd_we_reg && (state_reg == RSP);
    assign o_illegal   = illegal_reg && (state_reg == RSP);

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Directed bench for csr_rmw_ctrl: a behavioural CSR RAM plus scoreboard queues
// for expected responses and RAM writes, each tagged with the cycle it must appear.
module tb_csr_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_uimm;
    logic [4:0]  req_rd_addr;
    logic        instret_tick;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        rsp_valid;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;

    always #5 clk = ~clk;

    csr_rmw_ctrl #(.MXLEN(32)) dut (
        .i_clk          (clk),
        .i_nrst         (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_addr     (req_addr),
        .i_req_funct3   (req_funct3),
        .i_req_rs1_data (req_rs1_data),
        .i_req_uimm     (req_uimm),
        .i_req_rd_addr  (req_rd_addr),
        .i_instret_tick (instret_tick),
        .o_ram_en       (ram_en),
        .o_ram_we       (ram_we),
        .o_ram_addr     (ram_addr),
        .o_ram_wdata    (ram_wdata),
        .i_ram_rdata    (ram_rdata),
        .o_rsp_valid    (rsp_valid),
        .o_rd_data      (rd_data),
        .o_rd_addr      (rd_addr),
        .o_rd_we        (rd_we),
        .o_illegal      (illegal)
    );

    // Behavioural single-port RAM, read data one cycle after the read enable.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Cycle number as seen between edges; equals mcycle when no counter write occurred.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic        chk_data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every cycle, RAM writes and responses must appear exactly when scheduled.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic exp_w;
            logic exp_r;
            exp_w = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            chk("ram_we", {63'b0, ram_we}, {63'b0, exp_w});
            if (exp_w) begin
                wr_t w;
                w = wr_q.pop_front();
                chk("ram_waddr", {52'b0, ram_addr}, {52'b0, w.addr});
                chk("ram_wdata", {32'b0, ram_wdata}, {32'b0, w.data});
                $display("cyc=%0d ram write addr=%h data=%h", cyc, ram_addr, ram_wdata);
            end
            exp_r = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
            chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, exp_r});
            if (exp_r) begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rsp_illegal", {63'b0, illegal}, {63'b0, r.ill});
                chk("rsp_rd_we", {63'b0, rd_we}, {63'b0, r.we});
                chk("rsp_rd_addr", {59'b0, rd_addr}, {59'b0, r.rd});
                if (r.chk_data) chk("rsp_rd_data", {32'b0, rd_data}, {32'b0, r.data});
                $display("cyc=%0d rsp rd_data=%h rd=%0d we=%0d ill=%0d",
                         cyc, rd_data, rd_addr, rd_we, illegal);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the following negedge (RD state).
    task automatic do_req(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] rs1,
                          input logic [4:0] u, input logic [4:0] rd, input logic push,
                          input logic [31:0] exp_data, input logic exp_chk, input logic exp_we,
                          input logic exp_ill, input logic exp_wr, input logic [31:0] exp_wdata);
        req_valid    = 1'b1;
        req_addr     = a;
        req_funct3   = f3;
        req_rs1_data = rs1;
        req_uimm     = u;
        req_rd_addr  = rd;
        chk("req_ready", {63'b0, req_ready}, 64'd1);
        if (push) begin
            rsp_q.push_back('{exp_data, rd, exp_we, exp_ill, exp_chk, cyc + 3});
            if (exp_wr) wr_q.push_back('{a, exp_wdata, cyc + 2});
        end
        $display("cyc=%0d req addr=%h f3=%b rs1=%h uimm=%h rd=%0d", cyc, a, f3, rs1, u, rd);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", {63'b0, (n < 20)}, 64'd1);
        @(negedge clk);
    endtask

    int          c;
    int          c_w;
    logic [63:0] v;

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_funct3   = '0;
        req_rs1_data = '0;
        req_uimm     = '0;
        req_rd_addr  = '0;
        instret_tick = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
        mem[12'h340] <= 32'h0000_00F0;
        mem[12'h305] <= 32'h0000_00FF;
        mem[12'h300] <= 32'h1234_5678;
        mem[12'h341] <= 32'hDEAD_BEEF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'b0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_rd_data", {32'b0, rd_data}, 64'd0);
        chk("rst_rd_addr", {59'b0, rd_addr}, 64'd0);
        chk("rst_rd_we", {63'b0, rd_we}, 64'd0);
        chk("rst_illegal", {63'b0, illegal}, 64'd0);
        chk("rst_ram_en", {63'b0, ram_en}, 64'd0);
        chk("rst_ram_we", {63'b0, ram_we}, 64'd0);
        chk("rst_ram_addr", {52'b0, ram_addr}, 64'd0);
        chk("rst_ram_wdata", {32'b0, ram_wdata}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", {63'b0, req_ready}, 64'd1);
        @(negedge clk);

        // RAM-backed CSR operations
        do_req(12'h340, 3'b010, 32'h0000_000F, 5'd5, 5'd3, 1'b1, 32'h0000_00F0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_00FF);
        wait_idle();
        do_req(12'h305, 3'b111, 32'h0, 5'h03, 5'd0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00FC);
        wait_idle();
        do_req(12'h300, 3'b010, 32'h0000_FFFF, 5'd0, 5'd5, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        do_req(12'h341, 3'b101, 32'h0, 5'h1F, 5'd4, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_001F);
        wait_idle();
        do_req(12'h340, 3'b011, 32'h0000_000F, 5'd1, 5'd9, 1'b1, 32'h0000_00FF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_00F0);
        wait_idle();

        // Illegal requests: reserved funct3 and writes to read-only space
        do_req(12'h340, 3'b000, 32'h1, 5'd1, 5'd2, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_idle();
        do_req(12'h340, 3'b100, 32'h1, 5'd1, 5'd6, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_idle();
        do_req(12'hC00, 3'b001, 32'h1, 5'd0, 5'd7, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_idle();
        do_req(12'hC00, 3'b010, 32'h1, 5'd1, 5'd8, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_idle();
        chk("mem_305", {32'b0, mem[12'h305]}, 64'h0000_00FC);

        // mcycle read, then write near the 32-bit boundary and observe the carry
        c = cyc;
        do_req(12'hC00, 3'b010, 32'h0, 5'd0, 5'd1, 1'b1, c + 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        c_w = cyc;
        do_req(12'hB00, 3'b001, 32'hFFFF_FFFE, 5'd0, 5'd0, 1'b1, c_w + 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        wait_idle();
        repeat (2) @(negedge clk);
        c = cyc;
        v = 64'hFFFF_FFFE + 64'(c + 2 - c_w - 3);
        do_req(12'hB80, 3'b010, 32'h0, 5'd0, 5'd1, 1'b1, v[63:32], 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        c = cyc;
        v = 64'hFFFF_FFFE + 64'(c + 2 - c_w - 3);
        do_req(12'hB00, 3'b010, 32'h0, 5'd0, 5'd1, 1'b1, v[31:0], 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();

        // minstret: high-half write keeps low half, then count ticks
        do_req(12'hB82, 3'b001, 32'h0000_0007, 5'd0, 5'd2, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        do_req(12'hB82, 3'b010, 32'h0, 5'd0, 5'd2, 1'b1, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        do_req(12'hB02, 3'b010, 32'h0, 5'd0, 5'd2, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        repeat (5) begin
            instret_tick = 1'b1;
            @(negedge clk);
            instret_tick = 1'b0;
            @(negedge clk);
        end
        do_req(12'hC02, 3'b010, 32'h0, 5'd0, 5'd3, 1'b1, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        do_req(12'hC82, 3'b010, 32'h0, 5'd0, 5'd3, 1'b1, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();

        // Reset during RD of a CSRRW: request abandoned, counters cleared
        do_req(12'h340, 3'b001, 32'hAAAA_5555, 5'd0, 5'd1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {63'b0, req_ready}, 64'd0);
        chk("midrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("midrst_ram_en", {63'b0, ram_en}, 64'd0);
        chk("midrst_ram_we", {63'b0, ram_we}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", {63'b0, req_ready}, 64'd1);
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("mem_340_kept", {32'b0, mem[12'h340]}, 64'h0000_00F0);
        do_req(12'hC02, 3'b010, 32'h0, 5'd0, 5'd4, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        do_req(12'hC82, 3'b010, 32'h0, 5'd0, 5'd4, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();
        c = cyc;
        do_req(12'hC00, 3'b110, 32'h0, 5'd0, 5'd4, 1'b1, c + 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
